// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: downstream request flags and arbiter states.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MemIdle  = 2'b00;
    localparam logic [1:0] MemRead  = 2'b01;
    localparam logic [1:0] MemWrite = 2'b10;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2,
        ArbResp  = 2'd3
    } arb_state_e;

    // 2'b11 is reserved and never counts as a request.
    function automatic logic is_request(input logic [1:0] flag);
        return (flag == MemRead) || (flag == MemWrite);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward from ptr_i,
// wrapping from N-1 back to 0.
module mem_port_arbiter_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Farthest offset first, so the requester nearest the pointer is written last and wins.
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = IdxW'((int'(ptr_i) + k) % int'(N));
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory controller port between N_PORTS requesters with round-robin arbitration.
// The winner is latched, issued downstream when not busy, and answered with a one-cycle done.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned MaskW = DATA_WIDTH / 8,
    localparam int unsigned IdxW  = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*N_PORTS-1:0]          req_rw_flag_i,
    input  logic [ADDR_WIDTH*N_PORTS-1:0] req_addr_i,
    input  logic [DATA_WIDTH*N_PORTS-1:0] req_w_data_i,
    input  logic [MaskW*N_PORTS-1:0]      req_w_mask_i,
    output logic [DATA_WIDTH*N_PORTS-1:0] req_r_data_o,
    output logic [N_PORTS-1:0]            req_busy_o,
    output logic [N_PORTS-1:0]            req_done_o,
    output logic [1:0]                    mem_rw_flag_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_w_data_o,
    output logic [MaskW-1:0]              mem_w_mask_o,
    input  logic [DATA_WIDTH-1:0]         mem_r_data_i,
    input  logic                          mem_busy_i,
    input  logic                          mem_done_i
);

    localparam logic [N_PORTS-1:0] PortOne = N_PORTS'(1);

    logic [1:0]            flag_a  [N_PORTS];
    logic [ADDR_WIDTH-1:0] addr_a  [N_PORTS];
    logic [DATA_WIDTH-1:0] wdata_a [N_PORTS];
    logic [MaskW-1:0]      wmask_a [N_PORTS];
    logic [N_PORTS-1:0]    cand;

    arb_state_e            state_q;
    logic [IdxW-1:0]       grant_q;
    logic [IdxW-1:0]       rr_ptr_q;
    logic [N_PORTS-1:0]    excl_q;
    logic [N_PORTS-1:0]    done_q;
    logic                  is_write_q;
    logic [1:0]            mem_flag_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [MaskW-1:0]      mem_wmask_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  pick_valid;
    logic [IdxW-1:0]       pick_idx;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign flag_a[i]  = req_rw_flag_i[2*i +: 2];
        assign addr_a[i]  = req_addr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
        assign wdata_a[i] = req_w_data_i[DATA_WIDTH*i +: DATA_WIDTH];
        assign wmask_a[i] = req_w_mask_i[MaskW*i +: MaskW];
        // A port just served may still show its old flag for one cycle.
        assign cand[i] = is_request(flag_a[i]) && !excl_q[i] && !done_q[i];
        assign req_r_data_o[DATA_WIDTH*i +: DATA_WIDTH] = done_q[i] ? rdata_q : '0;
    end

    mem_port_arbiter_rr_pick #(
        .N (N_PORTS)
    ) u_rr_pick (
        .req_i   (cand),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            excl_q      <= '0;
            done_q      <= '0;
            is_write_q  <= 1'b0;
            mem_flag_q  <= MemIdle;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                ArbIdle: begin
                    excl_q <= '0;
                    if (pick_valid) begin
                        grant_q     <= pick_idx;
                        is_write_q  <= (flag_a[pick_idx] == MemWrite);
                        mem_flag_q  <= flag_a[pick_idx];
                        mem_addr_q  <= addr_a[pick_idx];
                        mem_wdata_q <= wdata_a[pick_idx];
                        mem_wmask_q <= wmask_a[pick_idx];
                        state_q     <= ArbIssue;
                    end
                end
                ArbIssue: begin
                    if (!mem_busy_i) begin
                        mem_flag_q  <= MemIdle;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        state_q     <= ArbWait;
                    end
                end
                ArbWait: begin
                    if (mem_done_i) begin
                        rdata_q <= is_write_q ? '0 : mem_r_data_i;
                        done_q  <= PortOne << grant_q;
                        state_q <= ArbResp;
                    end
                end
                ArbResp: begin
                    done_q   <= '0;
                    rdata_q  <= '0;
                    rr_ptr_q <= (grant_q == IdxW'(N_PORTS - 1)) ? '0 : grant_q + IdxW'(1);
                    excl_q   <= PortOne << grant_q;
                    state_q  <= ArbIdle;
                end
            endcase
        end
    end

    assign req_busy_o    = {N_PORTS{state_q != ArbIdle}};
    assign req_done_o    = done_q;
    assign mem_rw_flag_o = mem_flag_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_w_data_o  = mem_wdata_q;
    assign mem_w_mask_o  = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for stall/reset corners,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*N-1:0]    req_rw_flag_i;
    logic [AW*N-1:0]   req_addr_i;
    logic [DW*N-1:0]   req_w_data_i;
    logic [MW*N-1:0]   req_w_mask_i;
    logic [DW*N-1:0]   req_r_data_o;
    logic [N-1:0]      req_busy_o;
    logic [N-1:0]      req_done_o;
    logic [1:0]        mem_rw_flag_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_w_data_o;
    logic [MW-1:0]     mem_w_mask_o;
    logic [DW-1:0]     mem_r_data_i;
    logic              mem_busy_i;
    logic              mem_done_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .N_PORTS    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_rw_flag_i (req_rw_flag_i),
        .req_addr_i    (req_addr_i),
        .req_w_data_i  (req_w_data_i),
        .req_w_mask_i  (req_w_mask_i),
        .req_r_data_o  (req_r_data_o),
        .req_busy_o    (req_busy_o),
        .req_done_o    (req_done_o),
        .mem_rw_flag_o (mem_rw_flag_o),
        .mem_addr_o    (mem_addr_o),
        .mem_w_data_o  (mem_w_data_o),
        .mem_w_mask_o  (mem_w_mask_o),
        .mem_r_data_i  (mem_r_data_i),
        .mem_busy_i    (mem_busy_i),
        .mem_done_i    (mem_done_i)
    );

    // Packed view: {busy, done, r_data[p1,p0], mem_flag, mem_addr, mem_w_data, mem_w_mask}
    function automatic logic [159:0] pack_exp(input logic [1:0] busy, input logic [1:0] done,
                                              input logic [63:0] rdata, input logic [1:0] mflag,
                                              input logic [31:0] maddr, input logic [31:0] mdata,
                                              input logic [3:0] mmask);
        return 160'({busy, done, rdata, mflag, maddr, mdata, mmask});
    endfunction

    function automatic logic [159:0] outs();
        return 160'({req_busy_o, req_done_o, req_r_data_o, mem_rw_flag_o, mem_addr_o,
                     mem_w_data_o, mem_w_mask_o});
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [1:0] f, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req_rw_flag_i[2*p +: 2]   = f;
        req_addr_i[32*p +: 32]    = a;
        req_w_data_i[32*p +: 32]  = d;
        req_w_mask_i[4*p +: 4]    = m;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_phase;  // 0 free, 1 issuing, 2 waiting for downstream, 3 responding
    int          m_port;
    int          m_ptr;
    int          m_stale;
    logic [1:0]  m_flag;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_mask;
    logic [31:0] m_rdata;

    logic [1:0]  rq_flag [N];
    logic [31:0] rq_addr [N];
    logic [31:0] rq_data [N];
    logic [3:0]  rq_mask [N];
    bit          active  [N];
    bit          saw_done[N];

    function automatic logic [159:0] model_out();
        logic [1:0]  busy;
        logic [1:0]  done;
        logic [63:0] rd;
        logic [1:0]  mflag;
        logic [31:0] ma;
        logic [31:0] mdat;
        logic [3:0]  mm;
        busy  = (m_phase != 0) ? 2'b11 : 2'b00;
        done  = '0;
        rd    = '0;
        mflag = '0;
        ma    = '0;
        mdat  = '0;
        mm    = '0;
        if (m_phase == 1) begin
            mflag = m_flag;
            ma    = m_addr;
            mdat  = m_data;
            mm    = m_mask;
        end
        if (m_phase == 3) begin
            done[m_port] = 1'b1;
            rd[32*m_port +: 32] = (m_flag == 2'b10) ? 32'h0 : m_rdata;
        end
        return pack_exp(busy, done, rd, mflag, ma, mdat, mm);
    endfunction

    task automatic model_step();
        case (m_phase)
            0: begin
                int w;
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_ptr + k) % N;
                    if (w < 0 && (rq_flag[p] == 2'b01 || rq_flag[p] == 2'b10) && p != m_stale)
                        w = p;
                end
                m_stale = -1;
                if (w >= 0) begin
                    m_port  = w;
                    m_flag  = rq_flag[w];
                    m_addr  = rq_addr[w];
                    m_data  = rq_data[w];
                    m_mask  = rq_mask[w];
                    m_phase = 1;
                end
            end
            1: if (!mem_busy_i) m_phase = 2;
            2: if (mem_done_i) begin
                m_rdata = mem_r_data_i;
                m_phase = 3;
            end
            default: begin
                m_ptr   = (m_port + 1) % N;
                m_stale = m_port;
                m_phase = 0;
            end
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         rst;
        logic [1:0]   f0;
        logic [1:0]   f1;
        logic         mb;
        logic         md;
        logic [31:0]  mrd;
        logic [159:0] exp;
    } vec_t;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] D0 = 32'hA5A5_A5A5;
    localparam logic [3:0]  M0 = 4'hF;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] D1 = 32'h1122_3344;
    localparam logic [3:0]  M1 = 4'b0011;

    vec_t vt [22];

    initial begin
        logic [159:0] busy_e;
        logic [159:0] hold_e;
        rst = 1'b1;
        req_rw_flag_i = '0;
        req_addr_i    = '0;
        req_w_data_i  = '0;
        req_w_mask_i  = '0;
        mem_r_data_i  = '0;
        mem_busy_i    = 1'b0;
        mem_done_i    = 1'b0;

        busy_e = pack_exp(2'b11, 2'b00, 64'h0, 2'b00, 32'h0, 32'h0, 4'h0);
        // single read on port 0, then stale flag held one cycle after done
        vt[0]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[1]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b00, 64'h0, 2'b01, A0, D0, M0)};
        vt[2]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, busy_e};
        vt[3]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b01, {32'h0, 32'hDEAD_BEEF}, 2'b00, 32'h0, 32'h0, 4'h0)};
        vt[4]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 160'h0};
        // reset restores the pointer; contended writes: port 0 then port 1
        vt[6]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[7]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[8]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 32'h0,
                   pack_exp(2'b11, 2'b00, 64'h0, 2'b10, A0, D0, M0)};
        vt[9]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b00, 64'h0, 2'b10, A0, D0, M0)};
        vt[10] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 32'hCAFE_F00D, busy_e};
        vt[11] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b01, 64'h0, 2'b00, 32'h0, 32'h0, 4'h0)};
        vt[12] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[13] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b00, 64'h0, 2'b10, A1, D1, M1)};
        vt[14] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, busy_e};
        vt[15] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 32'h1234_5678, busy_e};
        vt[16] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,
                   pack_exp(2'b11, 2'b10, 64'h0, 2'b00, 32'h0, 32'h0, 4'h0)};
        vt[17] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 160'h0};
        // reserved flag 11 is never granted; stray downstream done is ignored
        vt[19] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0, 160'h0};
        vt[20] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 32'h7777_7777, 160'h0};
        vt[21] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 32'h0, 160'h0};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", outs(), 160'h0);
        next_cycle();
        rst = 1'b0;

        for (int r = 0; r < 22; r++) begin
            rst = vt[r].rst;
            set_port(0, vt[r].f0, A0, D0, M0);
            set_port(1, vt[r].f1, A1, D1, M1);
            mem_busy_i   = vt[r].mb;
            mem_done_i   = vt[r].md;
            mem_r_data_i = vt[r].mrd;
            @(negedge clk);
            chk($sformatf("vec%0d", r), outs(), vt[r].exp);
            next_cycle();
        end

        // busy stall: request held for six cycles, inputs changed after grant have no effect
        set_port(0, 2'b10, 32'h3000, 32'h55AA_55AA, 4'b1010);
        set_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        mem_busy_i = 1'b1;
        mem_done_i = 1'b0;
        @(negedge clk);
        chk("stall_idle", outs(), 160'h0);
        next_cycle();
        hold_e = pack_exp(2'b11, 2'b00, 64'h0, 2'b10, 32'h3000, 32'h55AA_55AA, 4'b1010);
        for (int i = 0; i < 6; i++) begin
            mem_busy_i = (i < 5);
            mem_done_i = (i == 1);
            if (i == 2) set_port(0, 2'b00, 32'hFFFF, 32'h0, 4'h0);
            @(negedge clk);
            chk($sformatf("stall_hold%0d", i), outs(), hold_e);
            next_cycle();
        end
        mem_busy_i = 1'b0;
        mem_done_i = 1'b0;
        @(negedge clk);
        chk("stall_wait0", outs(), busy_e);
        next_cycle();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h0BAD_F00D;
        @(negedge clk);
        chk("stall_wait1", outs(), busy_e);
        next_cycle();
        mem_done_i = 1'b0;
        @(negedge clk);
        chk("stall_resp", outs(), pack_exp(2'b11, 2'b01, 64'h0, 2'b00, 32'h0, 32'h0, 4'h0));
        next_cycle();

        // reset while waiting: transaction abandoned, late done ignored, pointer back to 0
        set_port(0, 2'b01, 32'h4000, 32'h0, 4'h0);
        set_port(1, 2'b01, 32'h5000, 32'h0, 4'h0);
        @(negedge clk);
        chk("rw_idle", outs(), 160'h0);
        next_cycle();
        @(negedge clk);
        chk("rw_issue", outs(), pack_exp(2'b11, 2'b00, 64'h0, 2'b01, 32'h5000, 32'h0, 4'h0));
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_wait", outs(), busy_e);
        next_cycle();
        rst = 1'b0;
        set_port(0, 2'b00, 32'h4000, 32'h0, 4'h0);
        set_port(1, 2'b00, 32'h5000, 32'h0, 4'h0);
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h9999_9999;
        @(negedge clk);
        chk("rw_after_rst", outs(), 160'h0);
        next_cycle();
        mem_done_i = 1'b0;
        @(negedge clk);
        chk("rw_no_done", outs(), 160'h0);
        next_cycle();
        set_port(0, 2'b01, 32'h4000, 32'h0, 4'h0);
        set_port(1, 2'b01, 32'h5000, 32'h0, 4'h0);
        @(negedge clk);
        chk("rw_idle2", outs(), 160'h0);
        next_cycle();
        @(negedge clk);
        chk("rw_ptr0", outs(), pack_exp(2'b11, 2'b00, 64'h0, 2'b01, 32'h4000, 32'h0, 4'h0));
        next_cycle();

        // randomized traffic against the reference model
        rst = 1'b1;
        set_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        set_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        next_cycle();
        rst = 1'b0;
        m_phase = 0;
        m_port  = 0;
        m_ptr   = 0;
        m_stale = -1;
        m_flag  = '0;
        m_addr  = '0;
        m_data  = '0;
        m_mask  = '0;
        m_rdata = '0;
        for (int p = 0; p < N; p++) begin
            rq_flag[p]  = '0;
            rq_addr[p]  = '0;
            rq_data[p]  = '0;
            rq_mask[p]  = '0;
            active[p]   = 1'b0;
            saw_done[p] = 1'b0;
        end

        for (int c = 0; c < 3000; c++) begin
            logic [159:0] exp;
            for (int p = 0; p < N; p++) begin
                if (saw_done[p]) begin
                    saw_done[p] = 1'b0;
                    active[p]   = 1'b0;
                    // either drop now or hold the stale flag for exactly one more cycle
                    if ($urandom_range(1) == 0) rq_flag[p] = 2'b00;
                end else if (active[p]) begin
                    if (rq_flag[p] == 2'b11 && $urandom_range(3) == 0) begin
                        rq_flag[p] = 2'b00;
                        active[p]  = 1'b0;
                    end else if ($urandom_range(7) == 0) begin
                        rq_addr[p] = $urandom();
                        rq_data[p] = $urandom();
                    end
                end else if ($urandom_range(2) == 0) begin
                    int r;
                    r = int'($urandom_range(9));
                    rq_flag[p] = (r < 4) ? 2'b01 : ((r < 8) ? 2'b10 : 2'b11);
                    rq_addr[p] = $urandom();
                    rq_data[p] = $urandom();
                    rq_mask[p] = 4'($urandom());
                    active[p]  = 1'b1;
                end else begin
                    rq_flag[p] = 2'b00;
                end
                set_port(p, rq_flag[p], rq_addr[p], rq_data[p], rq_mask[p]);
            end
            mem_busy_i   = ($urandom_range(2) == 0);
            mem_done_i   = ($urandom_range(2) == 0);
            mem_r_data_i = $urandom();
            exp = model_out();
            @(negedge clk);
            chk($sformatf("rand%0d", c), outs(), exp);
            if (m_phase == 3) saw_done[m_port] = 1'b1;
            model_step();
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
